// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic light controller.
`timescale 1ns/1ps
package traffic_pkg;

    localparam int NS_CNT_W = 5;
    localparam int EW_CNT_W = 4;
    localparam int Y_CNT_W  = 2;

    localparam int DEF_NS_GREEN_CYCLES = 32;
    localparam int DEF_EW_GREEN_CYCLES = 16;
    localparam int DEF_YELLOW_CYCLES   = 4;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        EW_GREEN  = 3'd2,
        EW_YELLOW = 3'd3,
        ALL_RED   = 3'd4
    } state_t;

endpackage

// File: rtl/traffic_light_controller_if.sv
// Sensor inputs, lamp outputs and debug taps (timer values, FSM state) of the controller.
`timescale 1ns/1ps
interface traffic_light_controller_if;
    import traffic_pkg::*;

    logic                NS_vehicle_detect;
    logic                EW_vehicle_detect;
    logic                NS_red;
    logic                NS_yellow;
    logic                NS_green;
    logic                EW_red;
    logic                EW_yellow;
    logic                EW_green;
    logic [NS_CNT_W-1:0] o_ns_count;
    logic [EW_CNT_W-1:0] o_ew_count;
    logic [Y_CNT_W-1:0]  o_yellow_count;
    state_t              state;

    // Level signals only, no valid/ready: detects are sampled on every rising
    // edge, lamps/counts/state are registered-state decodes valid all cycle.
    modport master (
        input  NS_vehicle_detect, EW_vehicle_detect,
        output NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green,
        output o_ns_count, o_ew_count, o_yellow_count, state
    );

    modport slave (
        output NS_vehicle_detect, EW_vehicle_detect,
        input  NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green,
        input  o_ns_count, o_ew_count, o_yellow_count, state
    );

endinterface

// File: rtl/phase_timer.sv
// Saturating up-counter: counts while enabled, clears to 0 when disabled, flags LIMIT-1.
`timescale 1ns/1ps
module phase_timer #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count != MAX) begin
            count <= count + WIDTH'(1);
        end
    end

    assign done = (count == MAX);

endmodule

// File: rtl/traffic_light_controller.sv
// Moore FSM NS green -> NS yellow -> EW green -> EW yellow with three phase timers.
// Define TRAFFIC_ALL_RED_EN to insert a 1-cycle all-red after every yellow.
`timescale 1ns/1ps
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int NS_GREEN_CYCLES = DEF_NS_GREEN_CYCLES,
    parameter int EW_GREEN_CYCLES = DEF_EW_GREEN_CYCLES,
    parameter int YELLOW_CYCLES   = DEF_YELLOW_CYCLES
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    traffic_light_controller_if.master  bus
);

    state_t              state;
    state_t              state_next;
    logic [NS_CNT_W-1:0] ns_count;
    logic [EW_CNT_W-1:0] ew_count;
    logic [Y_CNT_W-1:0]  y_count;
    logic                ns_done;
    logic                ew_done;
    logic                y_done;
    logic                ns_en;
    logic                ew_en;
    logic                y_en;
    logic [5:0]          lamps;

    // A timer runs only while its phase persists; the entry and exit edges
    // clear it, so it reads 0 in every state other than its own phase.
    assign ns_en = (state == NS_GREEN) && (state_next == NS_GREEN);
    assign ew_en = (state == EW_GREEN) && (state_next == EW_GREEN);
    assign y_en  = ((state == NS_YELLOW) || (state == EW_YELLOW)) && (state_next == state);

    phase_timer #(.WIDTH(NS_CNT_W), .LIMIT(NS_GREEN_CYCLES)) u_ns_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (ns_en),
        .count   (ns_count),
        .done    (ns_done)
    );

    phase_timer #(.WIDTH(EW_CNT_W), .LIMIT(EW_GREEN_CYCLES)) u_ew_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (ew_en),
        .count   (ew_count),
        .done    (ew_done)
    );

    phase_timer #(.WIDTH(Y_CNT_W), .LIMIT(YELLOW_CYCLES)) u_y_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .enable  (y_en),
        .count   (y_count),
        .done    (y_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= NS_GREEN;
        end else begin
            state <= state_next;
        end
    end

`ifdef TRAFFIC_ALL_RED_EN
    // Remembers which green follows the shared ALL_RED state.
    logic ew_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ew_next <= 1'b0;
        end else if (state == NS_YELLOW) begin
            ew_next <= 1'b1;
        end else if (state == EW_YELLOW) begin
            ew_next <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            NS_GREEN: begin
                if (ns_done && bus.EW_vehicle_detect) state_next = NS_YELLOW;
            end
            NS_YELLOW: begin
`ifdef TRAFFIC_ALL_RED_EN
                if (y_done) state_next = ALL_RED;
`else
                if (y_done) state_next = EW_GREEN;
`endif
            end
            EW_GREEN: begin
                if (ew_done || (!bus.EW_vehicle_detect && bus.NS_vehicle_detect))
                    state_next = EW_YELLOW;
            end
            EW_YELLOW: begin
`ifdef TRAFFIC_ALL_RED_EN
                if (y_done) state_next = ALL_RED;
`else
                if (y_done) state_next = NS_GREEN;
`endif
            end
`ifdef TRAFFIC_ALL_RED_EN
            ALL_RED: begin
                state_next = ew_next ? EW_GREEN : NS_GREEN;
            end
`endif
            default: begin
                state_next = NS_GREEN;
            end
        endcase
    end

    // Lamp order {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green};
    // anything unexpected shows red on both roads.
    always_comb begin
        lamps = 6'b100_100;
        case (state)
            NS_GREEN:  lamps = 6'b001_100;
            NS_YELLOW: lamps = 6'b010_100;
            EW_GREEN:  lamps = 6'b100_001;
            EW_YELLOW: lamps = 6'b100_010;
            default:   lamps = 6'b100_100;
        endcase
    end

    assign bus.NS_red         = lamps[5];
    assign bus.NS_yellow      = lamps[4];
    assign bus.NS_green       = lamps[3];
    assign bus.EW_red         = lamps[2];
    assign bus.EW_yellow      = lamps[1];
    assign bus.EW_green       = lamps[0];
    assign bus.o_ns_count     = ns_count;
    assign bus.o_ew_count     = ew_count;
    assign bus.o_yellow_count = y_count;
    assign bus.state          = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller; honours TRAFFIC_ALL_RED_EN for the expected schedule.
`timescale 1ns/1ps
module tb_traffic_light_controller;
    import traffic_pkg::*;

`ifdef TRAFFIC_ALL_RED_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif
    localparam int P_NSY   = 32;
    localparam int P_AR1   = P_NSY + 4;
    localparam int P_EWG   = P_AR1 + AR;
    localparam int P_EWY   = P_EWG + 16;
    localparam int P_AR2   = P_EWY + 4;
    localparam int PERIOD  = P_AR2 + AR;

    typedef struct packed {
        state_t     st;
        logic [5:0] lamps;
        logic [4:0] ns;
        logic [3:0] ew;
        logic [1:0] y;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    traffic_light_controller_if bus ();

    traffic_light_controller dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs k cycles after reset release, both detects held at 1.
    function automatic exp_t model_at(int k);
        exp_t e;
        int   p;
        p = k % PERIOD;
        e = '0;
        if (p < P_NSY) begin
            e.st = NS_GREEN;  e.lamps = 6'b001_100; e.ns = 5'(p);
        end else if (p < P_AR1) begin
            e.st = NS_YELLOW; e.lamps = 6'b010_100; e.y = 2'(p - P_NSY);
        end else if (p < P_EWG) begin
            e.st = ALL_RED;   e.lamps = 6'b100_100;
        end else if (p < P_EWY) begin
            e.st = EW_GREEN;  e.lamps = 6'b100_001; e.ew = 4'(p - P_EWG);
        end else if (p < P_AR2) begin
            e.st = EW_YELLOW; e.lamps = 6'b100_010; e.y = 2'(p - P_EWY);
        end else begin
            e.st = ALL_RED;   e.lamps = 6'b100_100;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.st    = bus.state;
        o.lamps = {bus.NS_red, bus.NS_yellow, bus.NS_green, bus.EW_red, bus.EW_yellow, bus.EW_green};
        o.ns    = bus.o_ns_count;
        o.ew    = bus.o_ew_count;
        o.y     = bus.o_yellow_count;
        return o;
    endfunction

    task automatic restart(input logic ns_det, input logic ew_det);
        @(negedge clk);
        rst_n = 1'b0;
        bus.NS_vehicle_detect = ns_det;
        bus.EW_vehicle_detect = ew_det;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        exp_t o;
        exp_t e;
        rst_n = 1'b0;
        bus.NS_vehicle_detect = 1'b0;
        bus.EW_vehicle_detect = 1'b0;
        #1;
        o = observed();
        e = '0;
        e.st = NS_GREEN;
        e.lamps = 6'b001_100;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", o, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) @(negedge clk);
            o = observed();
            e.ns = (k > 31) ? 5'd31 : 5'(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rest_no_demand k=%0d got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_const_demand();
        exp_t o;
        exp_t e;
        restart(1'b1, 1'b1);
        for (int k = 0; k < 2 * PERIOD; k++) begin
            if (k > 0) @(negedge clk);
            o = observed();
            e = model_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL const_demand k=%0d got %h expected %h", k, o, e);
            end
            checks++;
            if (($countones(o.lamps[5:3]) != 1) || ($countones(o.lamps[2:0]) != 1)
                || (!o.lamps[5] && !o.lamps[2])) begin
                errors++;
                $display("FAIL lamp_safety k=%0d lamps %b required one-hot per road, one road red", k, o.lamps);
            end
        end
    endtask

    task automatic test_gap_out();
        exp_t o;
        exp_t e;
        restart(1'b1, 1'b1);
        for (int k = 0; k <= P_EWG + 5; k++) begin
            if (k > 0) @(negedge clk);
            o = observed();
            e = model_at(k);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gap_lead_in k=%0d got %h expected %h", k, o, e);
            end
        end
        bus.EW_vehicle_detect = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            o = observed();
            e = '0;
            e.st = EW_YELLOW;
            e.lamps = 6'b100_010;
            e.y = 2'(j);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gap_out_yellow j=%0d got %h expected %h", j, o, e);
            end
        end
        bus.EW_vehicle_detect = 1'b1;
        @(negedge clk);
        if (AR == 1) begin
            o = observed();
            e = '0;
            e.st = ALL_RED;
            e.lamps = 6'b100_100;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gap_all_red got %h expected %h", o, e);
            end
            @(negedge clk);
        end
        o = observed();
        e = '0;
        e.st = NS_GREEN;
        e.lamps = 6'b001_100;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL gap_back_to_ns got %h expected %h", o, e);
        end
    endtask

    task automatic test_alternate();
        int run;
        int yellows;
        restart(1'b1, 1'b0);
        run = 0;
        yellows = 0;
        fork
            begin
                repeat (38) begin
                    #26;
                    bus.NS_vehicle_detect = ~bus.NS_vehicle_detect;
                    bus.EW_vehicle_detect = ~bus.EW_vehicle_detect;
                end
            end
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    checks++;
                    if (!bus.NS_red && !bus.EW_red) begin
                        errors++;
                        $display("FAIL alt_conflict c=%0d NS_red %b EW_red %b required at least one red", c, bus.NS_red, bus.EW_red);
                    end
                    checks++;
                    if (($countones({bus.NS_red, bus.NS_yellow, bus.NS_green}) != 1)
                        || ($countones({bus.EW_red, bus.EW_yellow, bus.EW_green}) != 1)) begin
                        errors++;
                        $display("FAIL alt_one_hot c=%0d NS %b%b%b EW %b%b%b required one lamp per road", c,
                                 bus.NS_red, bus.NS_yellow, bus.NS_green, bus.EW_red, bus.EW_yellow, bus.EW_green);
                    end
                    if (bus.NS_yellow || bus.EW_yellow) begin
                        run++;
                        checks++;
                        if (int'(bus.o_yellow_count) != run - 1) begin
                            errors++;
                            $display("FAIL alt_yellow_count c=%0d got %0d expected %0d", c, bus.o_yellow_count, run - 1);
                        end
                    end else if (run != 0) begin
                        yellows++;
                        checks++;
                        if (run != 4) begin
                            errors++;
                            $display("FAIL alt_yellow_len c=%0d got %0d expected 4", c, run);
                        end
                        run = 0;
                    end
                end
            end
        join
        checks++;
        if (yellows < 2) begin
            errors++;
            $display("FAIL alt_yellow_seen got %0d yellow phases expected at least 2", yellows);
        end
    endtask

    task automatic test_reset_mid();
        exp_t o;
        exp_t e;
        restart(1'b1, 1'b1);
        for (int k = 0; k <= P_EWG + 3; k++) begin
            if (k > 0) @(negedge clk);
        end
        o = observed();
        e = model_at(P_EWG + 3);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mid_pre_reset got %h expected %h", o, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        o = observed();
        e = '0;
        e.st = NS_GREEN;
        e.lamps = 6'b001_100;
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mid_reset_immediate got %h expected %h", o, e);
        end
        @(negedge clk);
        o = observed();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL mid_reset_held got %h expected %h", o, e);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_const_demand();
        test_gap_out();
        test_alternate();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
Two-road (north-south / east-west) traffic-light controller with integrated phase timers.
- A Moore FSM sequences NS green → NS yellow → EW green → EW yellow.
- Phase lengths come from three internal up-counters: a 5-bit NS-green timer, a 4-bit EW-green timer and a 2-bit yellow timer.
- Vehicle-detect inputs decide when the green phases end.
- Sits between the road-sensor front end and the lamp drivers; counter values are also exported for debug.

Parameters:
- NS_GREEN_CYCLES, 32, minimum NS green length in clock cycles; range 2..32 (fits the 5-bit counter).
- EW_GREEN_CYCLES, 16, maximum EW green length in clock cycles; range 2..16 (fits the 4-bit counter).
- YELLOW_CYCLES, 4, exact yellow length in clock cycles for either road; range 2..4 (fits the 2-bit counter).

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- NS_vehicle_detect  input  1  vehicle waiting or present on NS road; sampled synchronously.
- EW_vehicle_detect  input  1  vehicle waiting or present on EW road; sampled synchronously.
- NS_red / NS_yellow / NS_green  output  1 each  NS lamps.
- EW_red / EW_yellow / EW_green  output  1 each  EW lamps.
- o_ns_count  output  5  NS-green timer value.
- o_ew_count  output  4  EW-green timer value.
- o_yellow_count  output  2  yellow timer value.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - state=NS_GREEN; all counters=0.
  - Outputs: NS_green=1, EW_red=1, all other lamps 0.
  - First cycle after deassertion counts as NS_GREEN cycle 0.
- Lamps decode combinationally from the state register only (Moore).
  - Each road has exactly one lamp lit.
  - Never both roads non-red at once.
- Counters:
  - A counter increments only while its phase is active.
  - It is synchronously held at 0 in every other state, so it always starts at 0 on phase entry.
  - It saturates at its limit (LIMIT-1) and never wraps.
- NS_GREEN: go to NS_YELLOW when o_ns_count==NS_GREEN_CYCLES-1 AND EW_vehicle_detect==1; otherwise stay.
  - NS green lasts at least NS_GREEN_CYCLES cycles.
  - It rests indefinitely (counter saturated) while EW_vehicle_detect=0.
- NS_YELLOW: go to EW_GREEN when o_yellow_count==YELLOW_CYCLES-1.
  - Exactly YELLOW_CYCLES cycles; detects ignored.
- EW_GREEN: go to EW_YELLOW when o_ew_count==EW_GREEN_CYCLES-1, OR gap-out (EW_vehicle_detect==0 AND NS_vehicle_detect==1).
  - Length is 1..EW_GREEN_CYCLES cycles.
  - If both detects are 0, EW green continues to max-out.
- EW_YELLOW: go to NS_GREEN when o_yellow_count==YELLOW_CYCLES-1; exactly YELLOW_CYCLES cycles.
- Detect inputs may change on any edge; they are evaluated on the clock edge where the transition condition is checked.
- Reset mid-phase: immediate return to the reset state; no yellow is issued.
- Illegal state encodings recover to NS_GREEN on the next clock.

Optional Feature:
TRAFFIC_ALL_RED_EN
- Defined: adds an ALL_RED state of exactly 1 cycle after each yellow, before the opposing green.
  - In ALL_RED all four directional lamps are red (NS_red=1, EW_red=1); all counters hold 0.
  - Full cycle with constant EW demand and no gap-out = 32+4+1+16+4+1 = 58 cycles.
- Undefined: yellow goes directly to the opposing green; full cycle = 56 cycles.

Decomposition:
- Shared package traffic_pkg holds:
  - state typedef enum {NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, ALL_RED};
  - counter width constants 5/4/2;
  - default cycle constants.
- One sub-module, phase_timer: parameterised width and limit; inputs i_clk, i_rst_n, enable; saturating up-counter with clear-when-disabled and a done flag.
  - Instantiated three times (NS, EW, yellow).
- The FSM and lamp decode live in the top module.

Test Plan:
1. Reset asserted, then released with both detects 0 → NS_green=1, EW_red=1 for 100 cycles; o_ns_count saturates at 31.
2. NS_detect=1, EW_detect=1 constant → NS green 32 cycles, NS yellow 4, EW green 16 (o_ew_count 0..15), EW yellow 4; period 56; lamps one-hot per road throughout.
3. EW_detect=1 until EW green cycle 5, then EW_detect=0 with NS_detect=1 → EW_YELLOW entered on the next edge (EW green = 6 cycles).
4. Alternate both detects every 26 ns (10 ns clock) for 1000 ns → no state where both roads are non-red; yellow always exactly 4 cycles.
5. Assert i_rst_n=0 mid-EW_GREEN, between clock edges → outputs return to NS_green/EW_red immediately, counters read 0.
6. Build with TRAFFIC_ALL_RED_EN under constant demand → a 1-cycle all-red after each yellow; period 58.
